// File: rtl/fcpu_pkg.sv
// Shared definitions for the fcpu boot path: byte width and loader state encoding.
package fcpu_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    LDR_HEADER,
    LDR_BODY,
    LDR_DONE
  } ldr_state_t;

endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// Packs a byte stream big-endian into DATA_W-bit words; word_valid_o pulses
// combinationally with the final byte so the word can be written on that same edge.
module word_assembler
  import fcpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              clear_i,
  input  logic [BYTE_W-1:0] byte_i,
  input  logic              byte_fire_i,
  output logic [DATA_W-1:0] word_o,
  output logic              word_valid_o
);

  localparam int BYTES = DATA_W / BYTE_W;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_byte;

  assign last_byte    = (cnt_q == CNT_W'(BYTES - 1));
  assign word_o       = (shift_q << BYTE_W) | DATA_W'(byte_i);
  assign word_valid_o = byte_fire_i && last_byte;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (byte_fire_i) begin
      shift_d = word_o;
      cnt_d   = last_byte ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Writable instruction memory filled by a serial boot loader (header count, then
// big-endian words from address 0). o_load_done holds the core in reset until loaded.
module instr_mem_loader
  import fcpu_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [BYTE_W-1:0] i_byte_data,
  input  logic              i_byte_valid,
  output logic              o_byte_ready,
  input  logic              i_reload,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  output logic [DATA_W-1:0] o_fetch_data,
  output logic              o_load_done,
  output logic              o_overflow,
  output logic [ADDR_W:0]   o_word_count
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CW    = (DATA_W > ADDR_W + 1) ? DATA_W : ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

  ldr_state_t        state_q, state_d;
  logic [DATA_W-1:0] n_q, n_d;
  logic [DATA_W-1:0] body_cnt_q, body_cnt_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] fetch_data_q;

  logic              byte_fire;
  logic              asm_clear;
  logic [DATA_W-1:0] asm_word;
  logic              asm_valid;
  logic              mem_we;

  logic [DATA_W-1:0] mem [DEPTH];

  assign o_byte_ready = (state_q != LDR_DONE);
  assign o_load_done  = (state_q == LDR_DONE);
  assign o_overflow   = overflow_q;
  assign o_word_count = word_cnt_q;
  assign o_fetch_data = fetch_data_q;
  assign byte_fire    = i_byte_valid && o_byte_ready;

  word_assembler #(
    .DATA_W(DATA_W)
  ) u_word_assembler (
    .clk          (clk),
    .nrst         (nrst),
    .clear_i      (asm_clear),
    .byte_i       (i_byte_data),
    .byte_fire_i  (byte_fire),
    .word_o       (asm_word),
    .word_valid_o (asm_valid)
  );

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    body_cnt_d = body_cnt_q;
    word_cnt_d = word_cnt_q;
    overflow_d = overflow_q;
    mem_we     = 1'b0;
    asm_clear  = 1'b0;
    unique case (state_q)
      LDR_HEADER: begin
        if (asm_valid) begin
          if (asm_word == '0) begin
            state_d = LDR_DONE;
          end else begin
            state_d = LDR_BODY;
            n_d     = asm_word;
            if (CW'(asm_word) > CW'(DEPTH_CNT)) overflow_d = 1'b1;
          end
        end
      end
      LDR_BODY: begin
        if (asm_valid) begin
          body_cnt_d = body_cnt_q + DATA_W'(1);
          // Words beyond the memory depth are still counted against N, just not stored.
          if (!word_cnt_q[ADDR_W]) begin
            mem_we     = 1'b1;
            word_cnt_d = word_cnt_q + (ADDR_W + 1)'(1);
          end
          if (body_cnt_d == n_q) state_d = LDR_DONE;
        end
      end
      LDR_DONE: begin
        if (i_reload) begin
          state_d    = LDR_HEADER;
          overflow_d = 1'b0;
          word_cnt_d = '0;
          body_cnt_d = '0;
          asm_clear  = 1'b1;
        end
      end
      default: state_d = LDR_HEADER;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= LDR_HEADER;
      n_q        <= '0;
      body_cnt_q <= '0;
      word_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      body_cnt_q <= body_cnt_d;
      word_cnt_q <= word_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Memory contents survive both reset and reload.
  always_ff @(posedge clk) begin
    if (mem_we) mem[word_cnt_q[ADDR_W-1:0]] <= asm_word;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) fetch_data_q <= '0;
    else       fetch_data_q <= mem[i_fetch_addr];
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: hand sequences for the boot-load corner
// cases plus a table of randomized loads checked against an array memory model.
module tb_instr_mem_loader;

  localparam int AW    = 2;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          nrst;
  logic [7:0]    i_byte_data;
  logic          i_byte_valid;
  logic          o_byte_ready;
  logic          i_reload;
  logic [AW-1:0] i_fetch_addr;
  logic [DW-1:0] o_fetch_data;
  logic          o_load_done;
  logic          o_overflow;
  logic [AW:0]   o_word_count;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] model_mem [DEPTH];
  bit            model_vld [DEPTH];
  logic [DW-1:0] body_q [$];

  typedef struct {
    logic [31:0] n;
    int          gap;
    int          exp_wc;
    bit          exp_ovf;
  } vec_t;

  vec_t vecs [6];

  instr_mem_loader #(
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .clk          (clk),
    .nrst         (nrst),
    .i_byte_data  (i_byte_data),
    .i_byte_valid (i_byte_valid),
    .o_byte_ready (o_byte_ready),
    .i_reload     (i_reload),
    .i_fetch_addr (i_fetch_addr),
    .o_fetch_data (o_fetch_data),
    .o_load_done  (o_load_done),
    .o_overflow   (o_overflow),
    .o_word_count (o_word_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int g;
    g = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
    for (int i = 0; i < g; i++) begin
      @(negedge clk);
      i_byte_valid = 1'b0;
    end
    @(negedge clk);
    i_byte_valid = 1'b1;
    i_byte_data  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, input bit last);
    for (int k = 3; k >= 0; k--) begin
      if (last && k == 0) chk("done_before_last_byte", DW'(o_load_done), 0);
      send_byte(w[k*8 +: 8], gap);
    end
    if (last) begin
      chk("done_after_last_byte", DW'(o_load_done), 1);
      chk("ready_low_in_done", DW'(o_byte_ready), 0);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    i_byte_valid = 1'b0;
  endtask

  task automatic chk_fetch(input int a, input logic [DW-1:0] e);
    @(negedge clk);
    i_fetch_addr = AW'(a);
    @(posedge clk);
    #1;
    chk($sformatf("fetch[%0d]", a), o_fetch_data, e);
  endtask

  task automatic check_mem();
    for (int i = 0; i < DEPTH; i++)
      if (model_vld[i]) chk_fetch(i, model_mem[i]);
  endtask

  task automatic fill_body(input int n);
    body_q.delete();
    for (int i = 0; i < n; i++) body_q.push_back($urandom);
  endtask

  // Load header n followed by body_q; the model keeps the first DEPTH words.
  task automatic do_load(input logic [31:0] n, input int gap);
    send_word(n, gap, body_q.size() == 0);
    foreach (body_q[i]) begin
      send_word(body_q[i], gap, i == body_q.size() - 1);
      if (i < DEPTH) begin
        model_mem[i] = body_q[i];
        model_vld[i] = 1'b1;
      end
    end
    idle();
    check_mem();
  endtask

  task automatic reload();
    @(negedge clk);
    i_reload = 1'b1;
    @(posedge clk);
    #1;
    chk("reload_done_low", DW'(o_load_done), 0);
    chk("reload_ready_high", DW'(o_byte_ready), 1);
    @(negedge clk);
    i_reload = 1'b0;
  endtask

  task automatic check_reset_vals();
    chk("rst_ready", DW'(o_byte_ready), 1);
    chk("rst_fetch", o_fetch_data, 0);
    chk("rst_done", DW'(o_load_done), 0);
    chk("rst_overflow", DW'(o_overflow), 0);
    chk("rst_word_count", DW'(o_word_count), 0);
  endtask

  initial begin
    logic [DW-1:0] old0;
    logic [31:0]   dead;

    vecs[0] = '{n: 32'd1, gap: 2, exp_wc: 1, exp_ovf: 1'b0};
    vecs[1] = '{n: 32'd4, gap: 0, exp_wc: 4, exp_ovf: 1'b0};
    vecs[2] = '{n: 32'd5, gap: 3, exp_wc: 4, exp_ovf: 1'b1};
    vecs[3] = '{n: 32'd2, gap: 4, exp_wc: 2, exp_ovf: 1'b0};
    vecs[4] = '{n: 32'd0, gap: 1, exp_wc: 0, exp_ovf: 1'b0};
    vecs[5] = '{n: 32'd3, gap: 1, exp_wc: 3, exp_ovf: 1'b0};
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = '0;
      model_vld[i] = 1'b0;
    end

    nrst         = 1'b0;
    i_byte_data  = '0;
    i_byte_valid = 1'b0;
    i_reload     = 1'b0;
    i_fetch_addr = '0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    nrst = 1'b1;

    // Basic load of three known words.
    body_q.delete();
    body_q.push_back(32'h11223344);
    body_q.push_back(32'h55667788);
    body_q.push_back(32'h9900AABB);
    do_load(32'd3, 0);
    chk("basic_wc", DW'(o_word_count), 3);
    chk("basic_ovf", DW'(o_overflow), 0);
    chk_fetch(1, 32'h55667788);

    // Overflow: 6 words into a 4-word memory.
    reload();
    fill_body(6);
    do_load(32'd6, 0);
    chk("ovf_wc", DW'(o_word_count), 4);
    chk("ovf_flag", DW'(o_overflow), 1);

    // Reload clears overflow; write/read collision on address 0 returns old data.
    reload();
    chk("reload_clears_ovf", DW'(o_overflow), 0);
    chk("reload_clears_wc", DW'(o_word_count), 0);
    old0 = model_mem[0];
    @(negedge clk);
    i_fetch_addr = '0;
    send_word(32'd1, 0, 1'b0);
    dead = 32'hDEADBEEF;
    for (int k = 3; k >= 1; k--) send_byte(dead[k*8 +: 8], 0);
    send_byte(dead[7:0], 0);
    chk("collide_old", o_fetch_data, old0);
    chk("collide_done", DW'(o_load_done), 1);
    @(posedge clk);
    #1;
    chk("collide_new", o_fetch_data, 32'hDEADBEEF);
    idle();
    model_mem[0] = 32'hDEADBEEF;
    check_mem();
    chk("dead_wc", DW'(o_word_count), 1);

    // Empty load.
    reload();
    body_q.delete();
    do_load(32'd0, 0);
    chk("empty_wc", DW'(o_word_count), 0);

    // Table of randomized loads, with and without mid-word valid gaps.
    for (int v = 0; v < 6; v++) begin
      reload();
      fill_body(int'(vecs[v].n));
      do_load(vecs[v].n, vecs[v].gap);
      chk($sformatf("vec%0d_wc", v), DW'(o_word_count), DW'(vecs[v].exp_wc));
      chk($sformatf("vec%0d_ovf", v), DW'(o_overflow), DW'(vecs[v].exp_ovf));
    end

    // Reset after 6 bytes of an overflowing load, then a fresh load.
    reload();
    send_word(32'd6, 0, 1'b0);
    send_byte(8'hA5, 0);
    send_byte(8'h5A, 0);
    chk("midload_ovf_set", DW'(o_overflow), 1);
    @(negedge clk);
    i_byte_valid = 1'b0;
    nrst         = 1'b0;
    #1;
    check_reset_vals();
    @(negedge clk);
    nrst = 1'b1;
    fill_body(2);
    do_load(32'd2, 1);
    chk("fresh_wc", DW'(o_word_count), 2);
    chk("fresh_ovf", DW'(o_overflow), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Parametrised, writable instruction memory with a serial boot loader, replacing the fixed initial-block instruction ROM in the fcpu top level. It accepts a byte stream from serial_interface, packs the bytes big-endian into DATA_W-bit words, and writes them from address 0 upward, with the word count given in a header. It serves the core's fetch port with one-cycle read latency. o_load_done gates the core's reset so that no instruction executes before the program is loaded.

## Interface
- ADDR_W, default 10: word address width; the memory depth is 2**ADDR_W words.
- DATA_W, default 32: instruction width; must be a multiple of 8. BYTES = DATA_W/8 (derived, not overridable).
- clk  in  1  single clock (ui_clk at top level)
- nrst  in  1  reset, asynchronous, active-low
- i_byte_data  in  8  byte from serial_interface o_data
- i_byte_valid  in  1  byte valid
- o_byte_ready  out  1  byte ready; a byte transfers when valid && ready
- i_reload  in  1  one-cycle pulse; restarts the load when in DONE
- i_fetch_addr  in  ADDR_W  core fetch address
- o_fetch_data  out  DATA_W  registered fetch data
- o_load_done  out  1  program loaded; the top level ANDs this into the core's nrst
- o_overflow  out  1  sticky; the header count exceeded the memory depth
- o_word_count  out  ADDR_W+1  number of words written in the current load

## Operation
- States: HEADER, BODY, DONE. Reset enters HEADER.
- Byte ready: o_byte_ready = 1 in HEADER and BODY, 0 in DONE.
- Byte packing: a BYTES-deep shift register collects bytes, first byte into the MSBs. A byte counter (0..BYTES-1) wraps on the final byte of each word.
- HEADER: BYTES bytes form the count N (DATA_W bits, unsigned).
  - N = 0: go to DONE directly.
  - Otherwise go to BODY and latch N.
  - If N > 2**ADDR_W, set o_overflow.
- BODY: each completed word is written to address o_word_count[ADDR_W-1:0] when o_word_count < 2**ADDR_W; otherwise it is consumed and discarded. A body-word counter increments on every completed word. o_word_count increments only on written words and saturates at 2**ADDR_W. When the body-word counter reaches N, go to DONE.
- DONE: o_load_done = 1.
  - i_reload returns to HEADER and clears o_load_done, o_overflow, o_word_count, the byte counter and the body-word counter.
  - Memory contents persist across reload.
  - i_reload outside DONE is ignored.
- Fetch: synchronous read in every state. On a same-address write and read in the same cycle, the read returns the old data (read-first).
- Memory contents are not reset; the simulation initial value is '0.

## Timing
- Reset values: o_byte_ready 1, o_fetch_data '0, o_load_done 0, o_overflow 0, o_word_count 0, state HEADER, counters 0.
- Fetch latency: address at edge k, data valid after edge k+1.
- Word write: occurs on the same edge that accepts the word's final byte; o_word_count updates on that edge.
- Last word: on the edge that accepts the final byte of word N, the state becomes DONE and o_load_done goes high. o_byte_ready is low from the next cycle.
- Reload: on the edge sampling i_reload in DONE, the state becomes HEADER. o_load_done is low and o_byte_ready high in the following cycle.
- A deasserted i_byte_valid in mid-word only stalls the load; there is no timeout.
- Asserting nrst mid-load aborts the load immediately; the partially written memory is retained.

## Structure
- Shared package (fcpu_pkg): BYTE_W = 8, typedef ldr_state_t {LDR_HEADER, LDR_BODY, LDR_DONE}.
- Sub-module word_assembler (parameter DATA_W): takes bytes, outputs a word plus a one-cycle word_valid, and has a clear input.
- The memory array and fetch register live in instr_mem_loader.

## Test plan
- Basic load: header 00 00 00 03, then words 11223344, 55667788, 9900AABB -> o_word_count 3, o_load_done high after the 12th data byte; fetching addresses 0/1/2 returns those words one cycle later.
- Empty load: header 00 00 00 00 -> DONE after the 4th byte, o_word_count 0, o_byte_ready low the next cycle.
- Overflow: ADDR_W=2, N=6 -> 4 words written, 2 consumed and discarded, o_overflow 1, o_word_count 4, DONE after 28 bytes.
- Stalls and collisions: random i_byte_valid gaps mid-word -> same memory image as with no gaps. Fetching the address being written in the same cycle -> old value returned.
- Reload: after DONE, pulse i_reload, then header N=1 with word DEADBEEF -> address 0 = DEADBEEF, address 1 unchanged, o_overflow cleared.
- Reset mid-load: assert nrst after 6 bytes -> all outputs return to reset values; a fresh load then completes normally.
